lcd_status_writer: RTL and testbench

- HD44780-compatible 16x2 character LCD driver: the receiving end of the lift controller's status interface.
- Consumes lift state (parado/subindo/descendo) and current floor with an update strobe.
- Runs the LCD power-up/init sequence, then renders a fixed 16-character status line on row 1.
- Sits beside the lift controller at top level and drives the LCD_* pins directly.

---
 rtl/lcd_status_pkg.sv | 70 +++++++
 rtl/lcd_byte_writer.sv | 76 +++++++
 rtl/lcd_status_writer.sv | 159 +++++++++++++++
 tb/tb_lcd_status_writer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_status_pkg.sv
// rtl/lcd_status_pkg.sv - shared encodings, LCD command bytes and status-line character lookup
package lcd_status_pkg;

  typedef enum logic [1:0] {
    ST_PARADO   = 2'd0,
    ST_SUBINDO  = 2'd1,
    ST_DESCENDO = 2'd2,
    ST_INVALID  = 2'd3
  } lift_state_e;

  typedef enum logic [2:0] {
    S_POWERUP,
    S_INIT,
    S_IDLE,
    S_HOME,
    S_LINE
  } fsm_e;

  typedef enum logic [1:0] {
    P_IDLE,
    P_SETUP,
    P_EN,
    P_WAIT
  } wr_phase_e;

  localparam logic [7:0] FUNC_SET = 8'h38;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] ENTRY    = 8'h06;
  localparam logic [7:0] HOME_L1  = 8'h80;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = FUNC_SET;
      2'd1:    cmd = DISP_ON;
      2'd2:    cmd = CLEAR;
      default: cmd = ENTRY;
    endcase
    return cmd;
  endfunction

  // Chars 0-7 are picked out of the 8-char state name by shifting; the rest is fixed text.
  function automatic logic [7:0] char_at(input logic [1:0] st, input logic [3:0] fl,
                                         input logic [3:0] idx);
    logic [63:0] name;
    logic [63:0] sel;
    logic [7:0]  ch;
    case (st)
      ST_PARADO:   name = "PARADO  ";
      ST_SUBINDO:  name = "SUBINDO ";
      ST_DESCENDO: name = "DESCENDO";
      default:     name = "--------";
    endcase
    sel = name >> {~idx[2:0], 3'b000};
    case (idx)
      4'd8:    ch = "A";
      4'd9:    ch = "N";
      4'd10:   ch = "D";
      4'd11:   ch = "A";
      4'd12:   ch = "R";
      4'd13:   ch = " ";
      4'd14:   ch = (fl <= 4'd8) ? (8'h30 + {4'h0, fl}) : "?";
      4'd15:   ch = " ";
      default: ch = sel[7:0];
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// rtl/lcd_byte_writer.sv - one HD44780 byte transfer: setup, EN pulse, post-EN wait
module lcd_byte_writer
  import lcd_status_pkg::*;
#(
  parameter int EN_CYCLES    = 16,
  parameter int STEP_CYCLES  = 2500,
  parameter int CLEAR_CYCLES = 100000,
  parameter int CNT_W        = 17
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  input  logic       i_rs,
  input  logic       i_long_wait,
  output logic       o_done,
  output logic [7:0] o_data,
  output logic       o_rs,
  output logic       o_en
);

  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);

  wr_phase_e        r_phase;
  logic [CNT_W-1:0] r_cnt;
  logic             r_long;
  logic [CNT_W-1:0] w_wait_last;
  logic             w_ready;

  assign w_wait_last = r_long ? CLEAR_LAST : STEP_LAST;
  assign o_done      = (r_phase == P_WAIT) && (r_cnt == w_wait_last);
  // Accepting on the final wait cycle lets bytes run back to back with no bubble.
  assign w_ready     = (r_phase == P_IDLE) || o_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phase <= P_IDLE;
      r_cnt   <= '0;
      r_long  <= 1'b0;
      o_data  <= 8'h00;
      o_rs    <= 1'b0;
      o_en    <= 1'b0;
    end else if (i_start && w_ready) begin
      o_data  <= i_byte;
      o_rs    <= i_rs;
      r_long  <= i_long_wait;
      r_phase <= P_SETUP;
      r_cnt   <= '0;
    end else begin
      case (r_phase)
        P_SETUP: begin
          r_phase <= P_EN;
          o_en    <= 1'b1;
          r_cnt   <= '0;
        end
        P_EN: begin
          if (r_cnt == EN_LAST) begin
            r_phase <= P_WAIT;
            o_en    <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        P_WAIT: begin
          if (o_done) r_phase <= P_IDLE;
          else        r_cnt   <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lcd_status_writer.sv
// rtl/lcd_status_writer.sv - LCD init sequencer and lift status line renderer
module lcd_status_writer
  import lcd_status_pkg::*;
#(
  parameter int INIT_CYCLES  = 750000,
  parameter int EN_CYCLES    = 16,
  parameter int STEP_CYCLES  = 2500,
  parameter int CLEAR_CYCLES = 100000
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [1:0] iState,
  input  logic [3:0] iFloor,
  input  logic       iUpdate,
  output logic       oBusy,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN
);

  localparam int MAX_WAIT = (INIT_CYCLES > CLEAR_CYCLES) ? INIT_CYCLES : CLEAR_CYCLES;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);

  fsm_e             r_state;
  logic [CNT_W-1:0] r_pwr_cnt;
  logic [3:0]       r_idx;
  logic [1:0]       r_snap_state;
  logic [3:0]       r_snap_floor;
  logic             r_pending;
  logic [1:0]       r_disp_state;
  logic [3:0]       r_disp_floor;
  logic             r_busy;

  fsm_e       w_next;
  logic       w_start;
  logic [7:0] w_byte;
  logic       w_rs;
  logic       w_long;
  logic       w_go_home;
  logic       w_done;

  // The next byte is chosen during the current byte's last wait cycle.
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_byte    = 8'h00;
    w_rs      = 1'b0;
    w_go_home = 1'b0;
    case (r_state)
      S_POWERUP: begin
        if (r_pwr_cnt == INIT_LAST) begin
          w_start = 1'b1;
          w_byte  = FUNC_SET;
          w_next  = S_INIT;
        end
      end
      S_INIT: begin
        if (w_done) begin
          if (r_idx != 4'd3) begin
            w_start = 1'b1;
            w_byte  = init_cmd(r_idx[1:0] + 2'd1);
          end else if (r_pending) begin
            w_go_home = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        if (r_pending) w_go_home = 1'b1;
      end
      S_HOME: begin
        if (w_done) begin
          w_start = 1'b1;
          w_rs    = 1'b1;
          w_byte  = char_at(r_disp_state, r_disp_floor, 4'd0);
          w_next  = S_LINE;
        end
      end
      S_LINE: begin
        if (w_done) begin
          if (r_idx != 4'd15) begin
            w_start = 1'b1;
            w_rs    = 1'b1;
            w_byte  = char_at(r_disp_state, r_disp_floor, r_idx + 4'd1);
          end else if (r_pending) begin
            w_go_home = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_POWERUP;
    endcase
    if (w_go_home) begin
      w_start = 1'b1;
      w_byte  = HOME_L1;
      w_rs    = 1'b0;
      w_next  = S_HOME;
    end
    w_long = !w_rs && (w_byte == CLEAR);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state      <= S_POWERUP;
      r_pwr_cnt    <= '0;
      r_idx        <= 4'd0;
      r_snap_state <= 2'd0;
      r_snap_floor <= 4'd0;
      r_pending    <= 1'b1;
      r_disp_state <= 2'd0;
      r_disp_floor <= 4'd0;
      r_busy       <= 1'b1;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      if (r_state == S_POWERUP && r_pwr_cnt != INIT_LAST) r_pwr_cnt <= r_pwr_cnt + 1'b1;
      if (r_state == S_POWERUP || r_state == S_HOME) r_idx <= 4'd0;
      else if (w_start && !w_go_home)                r_idx <= r_idx + 4'd1;
      // A fresh update wins over the clear on HOME entry, so it still gets its own line.
      if (iUpdate) begin
        r_snap_state <= iState;
        r_snap_floor <= iFloor;
        r_pending    <= 1'b1;
      end else if (w_go_home) begin
        r_pending <= 1'b0;
      end
      if (w_go_home) begin
        r_disp_state <= r_snap_state;
        r_disp_floor <= r_snap_floor;
      end
    end
  end

  lcd_byte_writer #(
    .EN_CYCLES   (EN_CYCLES),
    .STEP_CYCLES (STEP_CYCLES),
    .CLEAR_CYCLES(CLEAR_CYCLES),
    .CNT_W       (CNT_W)
  ) u_byte (
    .i_clk      (iCLK),
    .i_rst      (iRST),
    .i_start    (w_start),
    .i_byte     (w_byte),
    .i_rs       (w_rs),
    .i_long_wait(w_long),
    .o_done     (w_done),
    .o_data     (LCD_DATA),
    .o_rs       (LCD_RS),
    .o_en       (LCD_EN)
  );

  assign oBusy  = r_busy;
  assign LCD_RW = 1'b0;

endmodule

// File: tb/tb_lcd_status_writer.sv
// tb/tb_lcd_status_writer.sv - directed bench with an expected-byte scoreboard for lcd_status_writer
module tb_lcd_status_writer;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic [1:0] iState = 2'd0;
  logic [3:0] iFloor = 4'd0;
  logic       iUpdate = 1'b0;
  logic       oBusy;
  logic [7:0] LCD_DATA;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_EN;

  lcd_status_writer #(
    .INIT_CYCLES (20),
    .EN_CYCLES   (2),
    .STEP_CYCLES (4),
    .CLEAR_CYCLES(8)
  ) dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iState  (iState),
    .iFloor  (iFloor),
    .iUpdate (iUpdate),
    .oBusy   (oBusy),
    .LCD_DATA(LCD_DATA),
    .LCD_RS  (LCD_RS),
    .LCD_RW  (LCD_RW),
    .LCD_EN  (LCD_EN)
  );

  always #5 iCLK = ~iCLK;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int n_rise     = 0;
  int first_rise = -1;
  logic [8:0] exp_q[$];

  always @(posedge iCLK) begin
    if (iRST) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Status-line model: state name, "ANDAR ", floor digit or '?', trailing blank.
  function automatic logic [7:0] line_char(input int st, input int fl, input int i);
    string s;
    case (st)
      0:       s = "PARADO  ";
      1:       s = "SUBINDO ";
      2:       s = "DESCENDO";
      default: s = "--------";
    endcase
    s = {s, "ANDAR "};
    if (i < 14)  return s[i];
    if (i == 14) return (fl <= 8) ? 8'(48 + fl) : 8'h3F;
    return 8'h20;
  endfunction

  task automatic push_init();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h006);
  endtask

  task automatic push_line(input int st, input int fl);
    exp_q.push_back(9'h080);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, line_char(st, fl, i)});
  endtask

  // Bus monitor: matches each EN pulse to the scoreboard and checks pulse shape and spacing.
  initial begin
    logic       prev_en;
    logic [8:0] prev_bus, held, last_byte;
    logic       have_last, idle_seen;
    int         en_len, last_rise;
    logic [8:0] e;
    prev_en = 1'b0; prev_bus = '0; held = '0; last_byte = '0;
    have_last = 1'b0; idle_seen = 1'b0; en_len = 0; last_rise = 0;
    forever begin
      @(negedge iCLK);
      if (iRST) begin
        prev_en = 1'b0; have_last = 1'b0; idle_seen = 1'b0; en_len = 0; first_rise = -1;
      end else begin
        check("rw_low", LCD_RW, 0);
        if (!oBusy) idle_seen = 1'b1;
        if (LCD_EN && !prev_en) begin
          n_rise++;
          if (first_rise < 0) first_rise = cyc;
          check("setup_to_en_stable", {LCD_RS, LCD_DATA}, prev_bus);
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_byte: got 0x%0h expected none", {LCD_RS, LCD_DATA});
          end else begin
            e = exp_q.pop_front();
            check("byte", {LCD_RS, LCD_DATA}, e);
          end
          if (have_last && !idle_seen)
            check("byte_spacing", cyc - last_rise, (last_byte == 9'h001) ? 11 : 7);
          last_rise = cyc; last_byte = {LCD_RS, LCD_DATA};
          have_last = 1'b1; idle_seen = 1'b0;
          held = {LCD_RS, LCD_DATA};
          en_len = 1;
        end else if (LCD_EN) begin
          en_len++;
          check("hold_during_en", {LCD_RS, LCD_DATA}, held);
        end else if (prev_en) begin
          check("en_width", en_len, 2);
        end
        prev_en  = LCD_EN;
        prev_bus = {LCD_RS, LCD_DATA};
      end
    end
  end

  task automatic upd(input int st, input int fl);
    @(negedge iCLK);
    iState  = 2'(st);
    iFloor  = 4'(fl);
    iUpdate = 1'b1;
    @(negedge iCLK);
    iUpdate = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output int n);
    n = 0;
    while (1) begin
      @(posedge iCLK);
      n++;
      @(negedge iCLK);
      if (!oBusy || n >= limit) break;
    end
  endtask

  task automatic measure_busy(input int limit, output int n);
    n = 0;
    for (int k = 0; k < limit; k++) begin
      @(negedge iCLK);
      if (oBusy) n++;
      else if (n > 0) break;
    end
  endtask

  task automatic wait_rises(input int target, input int limit, input string name);
    int k;
    for (k = 0; k < limit; k++) begin
      @(negedge iCLK);
      if (n_rise >= target) break;
    end
    if (k >= limit) check(name, n_rise, target);
  endtask

  initial begin
    int n, base;

    check("model_pin_descendo_o", line_char(2, 3, 7), 8'h4F);
    check("model_pin_floor5", line_char(1, 5, 14), 8'h35);
    check("model_pin_floor12", line_char(3, 12, 14), 8'h3F);
    check("model_pin_andar_a", line_char(0, 0, 8), 8'h41);

    repeat (3) @(negedge iCLK);
    check("rst_data", LCD_DATA, 0);
    check("rst_rs", LCD_RS, 0);
    check("rst_en", LCD_EN, 0);
    check("rst_rw", LCD_RW, 0);
    check("rst_busy", oBusy, 1);

    // 1: power-up, init and automatic first line
    push_init();
    push_line(0, 0);
    iRST = 1'b0;
    wait_idle(400, n);
    check("s1_busy_fall", n, 171);
    check("s1_first_en", first_rise, 21);
    check("s1_queue_empty", exp_q.size(), 0);

    // 2: single update from IDLE
    push_line(1, 5);
    upd(1, 5);
    measure_busy(400, n);
    check("s2_busy_len", n, 119);
    check("s2_queue_empty", exp_q.size(), 0);

    // 3: updates during a line collapse to the latest one
    push_line(2, 3);
    push_line(0, 4);
    base = n_rise;
    upd(2, 3);
    wait_rises(base + 7, 400, "s3_reach_byte6");
    upd(1, 7);
    wait_rises(base + 10, 400, "s3_reach_byte9");
    upd(0, 4);
    wait_idle(600, n);
    check("s3_idle", oBusy, 0);
    repeat (60) @(negedge iCLK);
    check("s3_byte_count", n_rise - base, 34);
    check("s3_queue_empty", exp_q.size(), 0);

    // 4: invalid state and out-of-range floor
    push_line(3, 12);
    upd(3, 12);
    measure_busy(400, n);
    check("s4_busy_len", n, 119);
    check("s4_queue_empty", exp_q.size(), 0);

    // 5: reset in the middle of an EN pulse, then full restart
    push_line(1, 2);
    base = n_rise;
    upd(1, 2);
    n = 0;
    while (!(LCD_EN && n_rise >= base + 5) && n < 400) begin
      @(negedge iCLK);
      n++;
    end
    check("s5_en_before_rst", LCD_EN, 1);
    #1 iRST = 1'b1;
    #1;
    check("s5_en_async_drop", LCD_EN, 0);
    check("s5_data_async_clear", LCD_DATA, 0);
    check("s5_rs_async_clear", LCD_RS, 0);
    exp_q.delete();
    repeat (3) @(negedge iCLK);
    check("s5_busy_in_rst", oBusy, 1);
    push_init();
    push_line(0, 0);
    iRST = 1'b0;
    wait_idle(400, n);
    check("s5_busy_fall", n, 171);
    check("s5_first_en", first_rise, 21);
    check("s5_queue_empty", exp_q.size(), 0);

    repeat (5) @(negedge iCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
